// File: rtl/lsu.sv
// Memory stage: loads, stores, LR/SC and AMO read-modify-write over a single-master data bus,
// with a registered one-slot writeback result.
package pipeline;
  localparam int XLEN = 64;

  typedef struct packed {
    logic [2:0]      funct3;
    logic            mm_re;
    logic            mm_we;
    logic            atomic;
    logic [4:0]      funct5;
    logic [XLEN-1:0] mm_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] data;
  } memory_signals;
endpackage

// state  | meaning
// IDLE   | ready to accept an op
// BUS    | single load/store/LR/SC transfer pending
// AMO_RD | AMO read of old value pending
// AMO_WR | AMO write of combined value pending
module lsu #(
  parameter int XLEN = pipeline::XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  pipeline::memory_signals signals_in,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [XLEN-1:0]       dbus_addr,
  output logic [XLEN/8-1:0]     dbus_sel,
  output logic [XLEN-1:0]       dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [XLEN-1:0]       dbus_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [4:0]            wb_rd_addr,
  output logic [XLEN-1:0]       wb_rd_data,
  output logic                  misaligned
);
  localparam int SB = XLEN / 8;
  localparam int LW = $clog2(SB);

  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [1:0] {IDLE, BUS, AMO_RD, AMO_WR} state_t;

  state_t           state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       funct5_q, funct5_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             we_q, we_d;
  logic             lr_q, lr_d;
  logic             sc_q, sc_d;
  logic [XLEN-1:0]  old_q, old_d;
  logic             resv_valid_q, resv_valid_d;
  logic [XLEN-LW-1:0] resv_tag_q, resv_tag_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_rd_addr_q, wb_rd_addr_d;
  logic [XLEN-1:0]  wb_rd_data_q, wb_rd_data_d;
  logic             misaligned_q, misaligned_d;

  logic [LW-1:0]    lane;
  logic [LW+2:0]    shamt;
  logic [SB-1:0]    size_mask;
  logic [XLEN-1:0]  rshift, load_ext;
  logic             sx;
  logic             w_op, lt_s, lt_u;
  logic [XLEN-1:0]  a_s, b_s, a_u, b_u, amo_res, wsrc;
  logic             is_lr, is_sc, is_amo, is_store, is_mem, in_mis, sc_ok;

  assign lane  = addr_q[LW-1:0];
  assign shamt = {lane, 3'b000};
  assign sx    = ~funct3_q[2];

  always_comb begin
    size_mask = '1;
    load_ext  = '0;
    rshift    = dbus_rdata >> shamt;
    case (funct3_q[1:0])
      2'b00: begin
        size_mask = SB'(1);
        load_ext  = {{(XLEN-8){sx & rshift[7]}}, rshift[7:0]};
      end
      2'b01: begin
        size_mask = SB'(3);
        load_ext  = {{(XLEN-16){sx & rshift[15]}}, rshift[15:0]};
      end
      2'b10: begin
        size_mask = SB'(15);
        load_ext  = {{(XLEN-32){sx & rshift[31]}}, rshift[31:0]};
      end
      default: begin
        size_mask = '1;
        load_ext  = rshift;
      end
    endcase
  end

  // W-size AMOs compare 32-bit operands; only the low word reaches the bus via the strobes
  always_comb begin
    w_op = (funct3_q[1:0] == 2'b10);
    a_s  = w_op ? {{(XLEN-32){old_q[31]}}, old_q[31:0]} : old_q;
    b_s  = w_op ? {{(XLEN-32){data_q[31]}}, data_q[31:0]} : data_q;
    a_u  = w_op ? {{(XLEN-32){1'b0}}, old_q[31:0]} : old_q;
    b_u  = w_op ? {{(XLEN-32){1'b0}}, data_q[31:0]} : data_q;
    lt_s = $signed(a_s) < $signed(b_s);
    lt_u = a_u < b_u;
    case (funct5_q)
      F5_SWAP: amo_res = data_q;
      F5_ADD:  amo_res = old_q + data_q;
      F5_XOR:  amo_res = old_q ^ data_q;
      F5_AND:  amo_res = old_q & data_q;
      F5_OR:   amo_res = old_q | data_q;
      F5_MIN:  amo_res = lt_s ? old_q : data_q;
      F5_MAX:  amo_res = lt_s ? data_q : old_q;
      F5_MINU: amo_res = lt_u ? old_q : data_q;
      F5_MAXU: amo_res = lt_u ? data_q : old_q;
      default: amo_res = old_q;
    endcase
  end

  always_comb begin
    wsrc       = (state_q == AMO_WR) ? amo_res : data_q;
    in_ready   = (state_q == IDLE);
    dbus_req   = (state_q != IDLE);
    dbus_we    = ((state_q == BUS) && we_q) || (state_q == AMO_WR);
    dbus_addr  = dbus_req ? {addr_q[XLEN-1:LW], {LW{1'b0}}} : '0;
    dbus_sel   = dbus_req ? (size_mask << lane) : '0;
    dbus_wdata = dbus_we ? (wsrc << shamt) : '0;
    wb_valid   = wb_valid_q;
    wb_we      = wb_we_q;
    wb_rd_addr = wb_rd_addr_q;
    wb_rd_data = wb_rd_data_q;
    misaligned = misaligned_q;
  end

  always_comb begin
    is_lr    = signals_in.atomic && (signals_in.funct5 == F5_LR);
    is_sc    = signals_in.atomic && (signals_in.funct5 == F5_SC);
    is_amo   = signals_in.atomic && !is_lr && !is_sc;
    is_store = signals_in.mm_we && !signals_in.atomic;
    is_mem   = signals_in.mm_re || signals_in.mm_we || signals_in.atomic;
    sc_ok    = resv_valid_q && (resv_tag_q == signals_in.mm_addr[XLEN-1:LW]);
    case (signals_in.funct3[1:0])
      2'b01:   in_mis = signals_in.mm_addr[0];
      2'b10:   in_mis = |signals_in.mm_addr[1:0];
      2'b11:   in_mis = |signals_in.mm_addr[2:0];
      default: in_mis = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    funct5_d     = funct5_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    data_d       = data_q;
    we_d         = we_q;
    lr_d         = lr_q;
    sc_d         = sc_q;
    old_d        = old_q;
    resv_valid_d = resv_valid_q;
    resv_tag_d   = resv_tag_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_data_d = wb_rd_data_q;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          funct3_d     = signals_in.funct3;
          funct5_d     = signals_in.funct5;
          addr_d       = signals_in.mm_addr;
          rd_d         = signals_in.rd_addr;
          data_d       = signals_in.data;
          we_d         = is_store || is_sc;
          lr_d         = is_lr;
          sc_d         = is_sc;
          wb_rd_addr_d = signals_in.rd_addr;
          if (is_sc) resv_valid_d = 1'b0;
          if (!is_mem) begin
            wb_valid_d   = 1'b1;
            wb_we_d      = (signals_in.rd_addr != 5'd0);
            wb_rd_data_d = signals_in.data;
          end else if (in_mis) begin
            wb_valid_d   = 1'b1;
            misaligned_d = 1'b1;
            wb_rd_data_d = '0;
          end else if (is_sc && !sc_ok) begin
            wb_valid_d   = 1'b1;
            wb_we_d      = (signals_in.rd_addr != 5'd0);
            wb_rd_data_d = XLEN'(1);
          end else if (is_amo) begin
            state_d = AMO_RD;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (dbus_ack) begin
          state_d      = IDLE;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = rd_q;
          if (we_q) begin
            wb_we_d      = sc_q && (rd_q != 5'd0);
            wb_rd_data_d = '0;
          end else begin
            wb_we_d      = (rd_q != 5'd0);
            wb_rd_data_d = load_ext;
          end
          if (lr_q) begin
            resv_valid_d = 1'b1;
            resv_tag_d   = addr_q[XLEN-1:LW];
          end
        end
      end
      AMO_RD: begin
        if (dbus_ack) begin
          old_d   = load_ext;
          state_d = AMO_WR;
        end
      end
      AMO_WR: begin
        if (dbus_ack) begin
          state_d      = IDLE;
          wb_valid_d   = 1'b1;
          wb_we_d      = (rd_q != 5'd0);
          wb_rd_addr_d = rd_q;
          wb_rd_data_d = old_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      funct5_q     <= '0;
      addr_q       <= '0;
      rd_q         <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      lr_q         <= 1'b0;
      sc_q         <= 1'b0;
      old_q        <= '0;
      resv_valid_q <= 1'b0;
      resv_tag_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_rd_data_q <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      funct5_q     <= funct5_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      we_q         <= we_d;
      lr_q         <= lr_d;
      sc_q         <= sc_d;
      old_q        <= old_d;
      resv_valid_q <= resv_valid_d;
      resv_tag_q   <= resv_tag_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
      misaligned_q <= misaligned_d;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected writebacks are queued at issue and checked as they retire.
module tb_lsu;
  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  pipeline::memory_signals signals_in;
  logic                    dbus_req, dbus_we, dbus_ack;
  logic [63:0]             dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]              dbus_sel;
  logic                    wb_valid, wb_we, misaligned;
  logic [4:0]              wb_rd_addr;
  logic [63:0]             wb_rd_data;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        chk_data;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wb_count = 0;
  int req_cycles = 0;
  int last_wb_cyc = 0;
  int accept_cyc = 0;

  lsu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .signals_in(signals_in), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (dbus_req) req_cycles++;
    if (wb_valid) begin
      wb_count++;
      last_wb_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h we=%b, required no writeback",
                 wb_rd_addr, wb_rd_data, wb_we);
      end else begin
        e = exp_q.pop_front();
        if (wb_we !== e.we || wb_rd_addr !== e.rd || misaligned !== e.mis ||
            (e.chk_data && wb_rd_data !== e.data)) begin
          errors++;
          $display("FAIL wb_result: got we=%b rd=%0d mis=%b data=%h, required we=%b rd=%0d mis=%b data=%h",
                   wb_we, wb_rd_addr, misaligned, wb_rd_data, e.we, e.rd, e.mis, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic we, input logic [4:0] rd, input logic [63:0] data,
                          input logic chk, input logic mis);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.chk_data = chk; e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] f3, input logic re, input logic we, input logic at,
                       input logic [4:0] f5, input logic [63:0] addr, input logic [4:0] rd,
                       input logic [63:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    signals_in.funct3  = f3;
    signals_in.mm_re   = re;
    signals_in.mm_we   = we;
    signals_in.atomic  = at;
    signals_in.funct5  = f5;
    signals_in.mm_addr = addr;
    signals_in.rd_addr = rd;
    signals_in.data    = data;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
    end
    accept_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic bus_serve(input int waits, input logic [63:0] rdata, output logic ok,
                           output logic held, output logic we, output logic [63:0] addr,
                           output logic [7:0] sel, output logic [63:0] wdata);
    ok = 1'b0; held = 1'b1; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dbus_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    we = dbus_we; addr = dbus_addr; sel = dbus_sel; wdata = dbus_wdata;
    repeat (waits) begin
      @(negedge clk);
      if (dbus_req !== 1'b1 || dbus_we !== we || dbus_addr !== addr ||
          dbus_sel !== sel || dbus_wdata !== wdata) held = 1'b0;
    end
    dbus_ack = 1'b1;
    dbus_rdata = rdata;
    @(posedge clk);
    #1 dbus_ack = 1'b0;
    dbus_rdata = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_timeout: %0d writebacks outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    signals_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b0 || wb_valid !== 1'b0 || wb_we !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b wbv=%b we=%b mis=%b, required all 0",
               dbus_req, wb_valid, wb_we, misaligned);
    end
    checks++;
    if (dbus_addr !== 64'd0 || dbus_sel !== 8'd0 || dbus_wdata !== 64'd0 || wb_rd_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%h sel=%h wdata=%h wbdata=%h, required 0",
               dbus_addr, dbus_sel, dbus_wdata, wb_rd_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_nonmem();
    push_exp(1'b1, 5'd5, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b0);
    issue(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 64'hCAFE_F00D_1234_5678);
    drain();
    checks++;
    if (last_wb_cyc - accept_cyc !== 1) begin
      errors++;
      $display("FAIL nonmem_latency: got %0d, required 1", last_wb_cyc - accept_cyc);
    end
    push_exp(1'b0, 5'd0, 64'h99, 1'b1, 1'b0);
    issue(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 64'h99);
    drain();
  endtask

  task automatic test_load();
    logic ok, held, we;
    logic [63:0] addr, wdata;
    logic [7:0] sel;
    push_exp(1'b1, 5'd10, 64'h1122334455667788, 1'b1, 1'b0);
    issue(3'b011, 1'b1, 1'b0, 1'b0, 5'd0, 64'h1000, 5'd10, 64'h0);
    bus_serve(3, 64'h1122334455667788, ok, held, we, addr, sel, wdata);
    checks++;
    if (!ok || !held || we !== 1'b0 || addr !== 64'h1000 || sel !== 8'hFF) begin
      errors++;
      $display("FAIL ld_bus: ok=%b held=%b we=%b addr=%h sel=%h, required 1 1 0 1000 ff",
               ok, held, we, addr, sel);
    end
    drain();
    checks++;
    if (last_wb_cyc - accept_cyc !== 5) begin
      errors++;
      $display("FAIL ld_latency: got %0d, required 5", last_wb_cyc - accept_cyc);
    end
    for (int k = 0; k < 2; k++) begin
      push_exp(1'b1, 5'd11, (k == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80, 1'b1, 1'b0);
      issue((k == 0) ? 3'b000 : 3'b100, 1'b1, 1'b0, 1'b0, 5'd0, 64'h1003, 5'd11, 64'h0);
      bus_serve(k, 64'h0000_0000_8000_0000, ok, held, we, addr, sel, wdata);
      checks++;
      if (!ok || !held || we !== 1'b0 || addr !== 64'h1000 || sel !== 8'h08) begin
        errors++;
        $display("FAIL lb_bus%0d: ok=%b held=%b we=%b addr=%h sel=%h, required 1 1 0 1000 08",
                 k, ok, held, we, addr, sel);
      end
      drain();
    end
  endtask

  task automatic test_store();
    logic ok, held, we;
    logic [63:0] addr, wdata;
    logic [7:0] sel;
    push_exp(1'b0, 5'd7, 64'h0, 1'b0, 1'b0);
    issue(3'b001, 1'b0, 1'b1, 1'b0, 5'd0, 64'h2006, 5'd7, 64'hBEEF);
    bus_serve(1, 64'h0, ok, held, we, addr, sel, wdata);
    checks++;
    if (!ok || !held || we !== 1'b1 || addr !== 64'h2000 || sel !== 8'hC0 ||
        wdata !== 64'hBEEF_0000_0000_0000) begin
      errors++;
      $display("FAIL sh_bus: ok=%b held=%b we=%b addr=%h sel=%h wdata=%h, required 1 1 1 2000 c0 beef000000000000",
               ok, held, we, addr, sel, wdata);
    end
    drain();
  endtask

  task automatic test_misaligned();
    int r0;
    r0 = req_cycles;
    push_exp(1'b0, 5'd3, 64'h0, 1'b0, 1'b1);
    issue(3'b010, 1'b1, 1'b0, 1'b0, 5'd0, 64'h3002, 5'd3, 64'h0);
    drain();
    checks++;
    if (last_wb_cyc - accept_cyc !== 1) begin
      errors++;
      $display("FAIL mis_latency: got %0d, required 1", last_wb_cyc - accept_cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (req_cycles !== r0) begin
      errors++;
      $display("FAIL mis_nobus: req cycles %0d, required 0", req_cycles - r0);
    end
  endtask

  task automatic test_lr_sc();
    logic ok, held, we;
    logic [63:0] addr, wdata;
    logic [7:0] sel;
    int r0;
    push_exp(1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    issue(3'b011, 1'b1, 1'b0, 1'b1, 5'b00010, 64'h4000, 5'd12, 64'h0);
    bus_serve(0, 64'h0123_4567_89AB_CDEF, ok, held, we, addr, sel, wdata);
    checks++;
    if (!ok || we !== 1'b0 || addr !== 64'h4000 || sel !== 8'hFF) begin
      errors++;
      $display("FAIL lr_bus: ok=%b we=%b addr=%h sel=%h, required 1 0 4000 ff", ok, we, addr, sel);
    end
    drain();
    push_exp(1'b1, 5'd13, 64'h0, 1'b1, 1'b0);
    issue(3'b011, 1'b0, 1'b1, 1'b1, 5'b00011, 64'h4000, 5'd13, 64'h55);
    bus_serve(2, 64'h0, ok, held, we, addr, sel, wdata);
    checks++;
    if (!ok || !held || we !== 1'b1 || addr !== 64'h4000 || sel !== 8'hFF || wdata !== 64'h55) begin
      errors++;
      $display("FAIL sc_bus: ok=%b held=%b we=%b addr=%h sel=%h wdata=%h, required 1 1 1 4000 ff 55",
               ok, held, we, addr, sel, wdata);
    end
    drain();
    r0 = req_cycles;
    push_exp(1'b1, 5'd14, 64'h1, 1'b1, 1'b0);
    issue(3'b011, 1'b0, 1'b1, 1'b1, 5'b00011, 64'h4000, 5'd14, 64'h66);
    drain();
    checks++;
    if (req_cycles !== r0) begin
      errors++;
      $display("FAIL sc_fail_nobus: req cycles %0d, required 0", req_cycles - r0);
    end
  endtask

  task automatic test_amo();
    logic [4:0]  t_f5[4]   = '{5'b00000, 5'b00001, 5'b10000, 5'b11100};
    logic [2:0]  t_f3[4]   = '{3'b010, 3'b010, 3'b011, 3'b010};
    logic [63:0] t_addr[4] = '{64'h5000, 64'h500C, 64'h5010, 64'h5018};
    logic [63:0] t_data[4] = '{64'h1, 64'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000};
    logic [63:0] t_rd[4]   = '{64'hAAAA_AAAA_7FFF_FFFF, 64'hDEAD_BEEF_0000_0000,
                               64'h5, 64'h0000_0000_7FFF_FFFF};
    logic [63:0] t_wd[4]   = '{64'h8000_0000, 64'h1234_5678_0000_0000,
                               64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000};
    logic [63:0] t_old[4]  = '{64'h7FFF_FFFF, 64'hFFFF_FFFF_DEAD_BEEF, 64'h5, 64'h7FFF_FFFF};
    logic [7:0]  t_sel[4]  = '{8'h0F, 8'hF0, 8'hFF, 8'h0F};
    logic [63:0] t_ba[4]   = '{64'h5000, 64'h5008, 64'h5010, 64'h5018};
    logic ok, held, we;
    logic [63:0] addr, wdata, m;
    logic [7:0] sel;
    for (int n = 0; n < 4; n++) begin
      m = '0;
      for (int k = 0; k < 8; k++) if (t_sel[n][k]) m[8*k +: 8] = 8'hFF;
      push_exp(1'b1, 5'd15, t_old[n], 1'b1, 1'b0);
      issue(t_f3[n], 1'b1, 1'b1, 1'b1, t_f5[n], t_addr[n], 5'd15, t_data[n]);
      bus_serve(n, t_rd[n], ok, held, we, addr, sel, wdata);
      checks++;
      if (!ok || !held || we !== 1'b0 || addr !== t_ba[n] || sel !== t_sel[n]) begin
        errors++;
        $display("FAIL amo_rd%0d: ok=%b held=%b we=%b addr=%h sel=%h, required 1 1 0 %h %h",
                 n, ok, held, we, addr, sel, t_ba[n], t_sel[n]);
      end
      bus_serve(1, 64'h0, ok, held, we, addr, sel, wdata);
      checks++;
      if (!ok || !held || we !== 1'b1 || addr !== t_ba[n] || sel !== t_sel[n] ||
          (wdata & m) !== (t_wd[n] & m)) begin
        errors++;
        $display("FAIL amo_wr%0d: ok=%b held=%b we=%b addr=%h sel=%h wdata=%h, required 1 1 1 %h %h %h",
                 n, ok, held, we, addr, sel, wdata, t_ba[n], t_sel[n], t_wd[n]);
      end
      drain();
    end
  endtask

  task automatic test_reset_amo();
    logic ok, held, we;
    logic [63:0] addr, wdata;
    logic [7:0] sel;
    int w0;
    issue(3'b010, 1'b1, 1'b1, 1'b1, 5'b00000, 64'h5000, 5'd15, 64'h1);
    bus_serve(0, 64'h7FFF_FFFF, ok, held, we, addr, sel, wdata);
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b1 || dbus_we !== 1'b1) begin
      errors++;
      $display("FAIL amo_wr_pending: req=%b we=%b, required 1 1", dbus_req, dbus_we);
    end
    w0 = wb_count;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop_req: req=%b, required 0", dbus_req);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wb_count !== w0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_wb: wb=%0d ready=%b, required 0 1", wb_count - w0, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    int w0;
    w0 = wb_count;
    push_exp(1'b1, 5'd20, 64'h1111, 1'b1, 1'b0);
    push_exp(1'b1, 5'd21, 64'h2222, 1'b1, 1'b0);
    issue(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 5'd20, 64'h1111);
    a0 = accept_cyc;
    issue(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 5'd21, 64'h2222);
    checks++;
    if (accept_cyc - a0 !== 1) begin
      errors++;
      $display("FAIL b2b_accept: gap %0d, required 1", accept_cyc - a0);
    end
    drain();
    checks++;
    if (wb_count - w0 !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d writebacks, required 2", wb_count - w0);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_misaligned();
    test_lr_sc();
    test_amo();
    test_back_to_back();
    test_reset_amo();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
